// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot image copier: FSM encoding, bus widths
// common with the flash/SRAM controllers, and default boot image placement.
package boot_copier_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLASH_RD = 3'd1,
    RAM_WR   = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } state_t;

  localparam int FLASH_AW_DEF = 22;
  localparam int RAM_AW_DEF   = 18;
  localparam int DW_DEF       = 16;
  localparam int LEN_W_DEF    = 16;

  localparam int          BOOT_SRC_DEF = 0;
  localparam int          BOOT_DST_DEF = 0;
  localparam logic [15:0] BOOT_LEN_DEF = 16'h021B;
  localparam int          TIMEOUT_DEF  = 1024;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/boot_copier_if.sv
// Flash read / SRAM write request-done bus between the copier and the two
// memory controllers.
interface boot_copier_if
  import boot_copier_pkg::*;
#(
  parameter int FLASH_AW = FLASH_AW_DEF,
  parameter int RAM_AW   = RAM_AW_DEF,
  parameter int DW       = DW_DEF
);
  logic                flash_req;
  logic [FLASH_AW:1]   flash_addr;
  logic                flash_done;
  logic [DW-1:0]       flash_data;
  logic                ram_req;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DW-1:0]       ram_data;
  logic                ram_done;

  modport master (
    output flash_req, flash_addr, ram_req, ram_addr, ram_data,
    input  flash_done, flash_data, ram_done
  );

  modport slave (
    input  flash_req, flash_addr, ram_req, ram_addr, ram_data,
    output flash_done, flash_data, ram_done
  );
endinterface

// File: rtl/boot_copier_timeout.sv
// Per-access wait watchdog: loaded on entry to a wait state, counts down
// while enabled, flags expiry in the last allowed cycle.
module boot_copier_timeout
  import boot_copier_pkg::*;
#(
  parameter int LOAD_VAL = TIMEOUT_DEF,
  parameter int W        = cnt_width(LOAD_VAL)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (load)               cnt <= W'(LOAD_VAL);
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  // LOAD_VAL of 0 disables the watchdog entirely.
  assign expired = (LOAD_VAL != 0) && en && (cnt == W'(1));
endmodule

// File: rtl/boot_copier.sv
// Flash-to-RAM boot image copier: reads one word from flash, writes it to
// RAM, repeats for len words; tracks checksum and count, holds CPU via boot_done.
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter int                FLASH_AW   = FLASH_AW_DEF,
  parameter int                RAM_AW     = RAM_AW_DEF,
  parameter int                DW         = DW_DEF,
  parameter int                LEN_W      = LEN_W_DEF,
  parameter bit                AUTO_START = 1'b1,
  parameter logic [FLASH_AW:1] DEF_SRC    = FLASH_AW'(BOOT_SRC_DEF),
  parameter logic [RAM_AW-1:0] DEF_DST    = RAM_AW'(BOOT_DST_DEF),
  parameter logic [LEN_W-1:0]  DEF_LEN    = LEN_W'(BOOT_LEN_DEF),
  parameter int                TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [FLASH_AW:1]   cfg_src,
  input  logic [RAM_AW-1:0]   cfg_dst,
  input  logic [LEN_W-1:0]    cfg_len,
  boot_copier_if.master       bus,
  output logic                busy,
  output logic                boot_done,
  output logic                error,
  output logic [DW-1:0]       checksum,
  output logic [LEN_W-1:0]    words_copied
);
  state_t              state, state_nxt;
  logic                auto_pend, auto_nxt;
  logic [FLASH_AW:1]   src, src_nxt, faddr, faddr_nxt;
  logic [RAM_AW-1:0]   dst, dst_nxt, raddr, raddr_nxt;
  logic [LEN_W-1:0]    len, len_nxt, wc_nxt, wc_inc;
  logic [DW-1:0]       rdata, rdata_nxt, csum_nxt;
  logic                freq, freq_nxt, rreq, rreq_nxt;
  logic                busy_nxt, bdone_nxt, err_nxt;
  logic                start_eff, tmo_expired, tmo_load, tmo_clr, tmo_en;
  logic [FLASH_AW:1]   sel_src;
  logic [RAM_AW-1:0]   sel_dst;
  logic [LEN_W-1:0]    sel_len;

  // The auto-start request masquerades as a start pulse with DEF_* config.
  assign start_eff = start | auto_pend;
  assign sel_src   = auto_pend ? DEF_SRC : cfg_src;
  assign sel_dst   = auto_pend ? DEF_DST : cfg_dst;
  assign sel_len   = auto_pend ? DEF_LEN : cfg_len;
  assign wc_inc    = words_copied + 1'b1;

  always_comb begin
    state_nxt = state;
    auto_nxt  = 1'b0;
    src_nxt   = src;
    dst_nxt   = dst;
    len_nxt   = len;
    faddr_nxt = faddr;
    raddr_nxt = raddr;
    rdata_nxt = rdata;
    freq_nxt  = freq;
    rreq_nxt  = rreq;
    busy_nxt  = busy;
    bdone_nxt = boot_done;
    err_nxt   = error;
    csum_nxt  = checksum;
    wc_nxt    = words_copied;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start_eff) begin
          src_nxt   = sel_src;
          dst_nxt   = sel_dst;
          len_nxt   = sel_len;
          csum_nxt  = '0;
          wc_nxt    = '0;
          err_nxt   = 1'b0;
          if (sel_len == '0) begin
            state_nxt = DONE;
            bdone_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = FLASH_RD;
            bdone_nxt = 1'b0;
            busy_nxt  = 1'b1;
            freq_nxt  = 1'b1;
            faddr_nxt = sel_src;
          end
        end
      end
      FLASH_RD: begin
        if (bus.flash_done) begin
          state_nxt = RAM_WR;
          rdata_nxt = bus.flash_data;
          freq_nxt  = 1'b0;
          rreq_nxt  = 1'b1;
          raddr_nxt = dst + RAM_AW'(words_copied);
        end else if (tmo_expired) begin
          state_nxt = ERROR;
          freq_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      RAM_WR: begin
        if (bus.ram_done) begin
          rreq_nxt = 1'b0;
          wc_nxt   = wc_inc;
          csum_nxt = checksum + rdata;
          if (wc_inc == len) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            bdone_nxt = 1'b1;
          end else begin
            state_nxt = FLASH_RD;
            freq_nxt  = 1'b1;
            faddr_nxt = src + FLASH_AW'(wc_inc);
          end
        end else if (tmo_expired) begin
          state_nxt = ERROR;
          rreq_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      auto_pend    <= AUTO_START;
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      faddr        <= '0;
      raddr        <= '0;
      rdata        <= '0;
      freq         <= 1'b0;
      rreq         <= 1'b0;
      busy         <= 1'b0;
      boot_done    <= 1'b0;
      error        <= 1'b0;
      checksum     <= '0;
      words_copied <= '0;
    end else begin
      state        <= state_nxt;
      auto_pend    <= auto_nxt;
      src          <= src_nxt;
      dst          <= dst_nxt;
      len          <= len_nxt;
      faddr        <= faddr_nxt;
      raddr        <= raddr_nxt;
      rdata        <= rdata_nxt;
      freq         <= freq_nxt;
      rreq         <= rreq_nxt;
      busy         <= busy_nxt;
      boot_done    <= bdone_nxt;
      error        <= err_nxt;
      checksum     <= csum_nxt;
      words_copied <= wc_nxt;
    end
  end

  assign bus.flash_req  = freq;
  assign bus.flash_addr = faddr;
  assign bus.ram_req    = rreq;
  assign bus.ram_addr   = raddr;
  assign bus.ram_data   = rdata;

  // Watchdog reloads on every entry into a wait state, including RAM_WR -> FLASH_RD.
  assign tmo_en   = (state == FLASH_RD) || (state == RAM_WR);
  assign tmo_clr  = !((state_nxt == FLASH_RD) || (state_nxt == RAM_WR));
  assign tmo_load = !tmo_clr && (state_nxt != state);

  boot_copier_timeout #(.LOAD_VAL(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );
endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: models flash/SRAM controllers answering
// after 3 cycles and checks copy results against hand-computed values.
module tb_boot_copier;
  logic              clk;
  logic              rst;
  logic              start;
  logic [22:1]       cfg_src;
  logic [17:0]       cfg_dst;
  logic [15:0]       cfg_len;
  logic              busy, boot_done, error;
  logic [15:0]       checksum, words_copied;

  boot_copier_if #(.FLASH_AW(22), .RAM_AW(18), .DW(16)) bus ();

  boot_copier #(
    .FLASH_AW(22), .RAM_AW(18), .DW(16), .LEN_W(16),
    .AUTO_START(1'b1), .DEF_SRC(22'd0), .DEF_DST(18'd0), .DEF_LEN(16'd4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .bus(bus),
    .busy(busy), .boot_done(boot_done), .error(error),
    .checksum(checksum), .words_copied(words_copied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Controller model state and transaction logs (written only by the responder).
  logic [22:1] flog [256];
  logic [17:0] rlog_addr [256];
  logic [15:0] rlog_data [256];
  int nf, nw, nreq, fcnt, rcnt;
  bit hold_flash, spur_ram;

  function automatic logic [15:0] fdata(input logic [22:1] a);
    logic [21:0] v;
    v = a;
    case (v)
      22'd0:   return 16'h1111;
      22'd1:   return 16'h2222;
      22'd2:   return 16'h3333;
      22'd3:   return 16'h4444;
      default: return v[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  initial begin
    bus.flash_done = 1'b0; bus.ram_done = 1'b0; bus.flash_data = '0;
    nf = 0; nw = 0; nreq = 0; fcnt = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      bus.flash_done = 1'b0;
      bus.ram_done   = 1'b0;
      if (bus.flash_req || bus.ram_req) nreq++;
      if (bus.flash_req) begin
        fcnt++;
        if (fcnt >= 3 && !hold_flash && nf < 256) begin
          bus.flash_done = 1'b1;
          bus.flash_data = fdata(bus.flash_addr);
          flog[nf] = bus.flash_addr;
          nf++;
          fcnt = 0;
        end
      end else fcnt = 0;
      if (bus.ram_req) begin
        rcnt++;
        if (rcnt >= 3 && nw < 256) begin
          bus.ram_done = 1'b1;
          rlog_addr[nw] = bus.ram_addr;
          rlog_data[nw] = bus.ram_data;
          nw++;
          rcnt = 0;
        end
      end else rcnt = 0;
      if (spur_ram) bus.ram_done = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [22:1] s, input logic [17:0] d, input logic [15:0] l);
    cfg_src = s; cfg_dst = d; cfg_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int c;
    c = 0;
    while (!(boot_done || error) && c < 400) begin
      tick();
      c++;
    end
    if (!(boot_done || error)) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: no completion within %0d cycles", name, c);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_flash_req"},  {31'd0, bus.flash_req}, 32'd0);
    chk({tag, "_flash_addr"}, {10'd0, bus.flash_addr}, 32'd0);
    chk({tag, "_ram_req"},    {31'd0, bus.ram_req}, 32'd0);
    chk({tag, "_ram_addr"},   {14'd0, bus.ram_addr}, 32'd0);
    chk({tag, "_ram_data"},   {16'd0, bus.ram_data}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
    chk({tag, "_boot_done"},  {31'd0, boot_done}, 32'd0);
    chk({tag, "_error"},      {31'd0, error}, 32'd0);
    chk({tag, "_checksum"},   {16'd0, checksum}, 32'd0);
    chk({tag, "_words"},      {16'd0, words_copied}, 32'd0);
  endtask

  typedef struct {
    logic [22:1] src;
    logic [17:0] dst;
    logic [15:0] len;
    logic [15:0] exp_csum;
  } case_t;

  case_t cases [4];

  initial begin
    int bf, bw, br;
    logic prev_bd;
    logic [22:1] ea;
    logic [17:0] ra;
    bit spur_done, st_done, got;

    cases[0] = '{22'h3FFFFE, 18'h3FFFF, 16'd3, 16'h5C5A};
    cases[1] = '{22'h000000, 18'h00100, 16'd4, 16'hAAAA};
    cases[2] = '{22'h000010, 18'h00020, 16'd2, 16'hB495};
    cases[3] = '{22'h000200, 18'h00300, 16'd0, 16'h0000};

    rst = 1'b0; start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    hold_flash = 1'b0; spur_ram = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("reset");

    // Auto-start boot of 4 words from DEF_SRC/DEF_DST.
    bf = nf; bw = nw;
    rst = 1'b1;
    tick();
    chk("auto_flash_req", {31'd0, bus.flash_req}, 32'd1);
    chk("auto_busy", {31'd0, busy}, 32'd1);
    prev_bd = boot_done;
    for (int c = 0; c < 200 && nw - bw < 4; c++) begin
      prev_bd = boot_done;
      tick();
    end
    chk("auto_bd_before", {31'd0, prev_bd}, 32'd0);
    chk("auto_bd_after", {31'd0, boot_done}, 32'd1);
    chk("auto_checksum", {16'd0, checksum}, 32'h0000AAAA);
    chk("auto_words", {16'd0, words_copied}, 32'd4);
    chk("auto_busy_end", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("auto_ram_addr", {14'd0, rlog_addr[bw + i]}, i);
      chk("auto_flash_addr", {10'd0, flog[bf + i]}, i);
    end

    // Table of runtime-configured copies.
    for (int k = 0; k < 4; k++) begin
      bf = nf; bw = nw; br = nreq;
      do_start(cases[k].src, cases[k].dst, cases[k].len);
      if (k == 3) begin
        chk("len0_boot_done_next", {31'd0, boot_done}, 32'd1);
        repeat (3) tick();
      end
      wait_end("case_wait");
      chk("case_boot_done", {31'd0, boot_done}, 32'd1);
      chk("case_error", {31'd0, error}, 32'd0);
      chk("case_busy", {31'd0, busy}, 32'd0);
      chk("case_checksum", {16'd0, checksum}, {16'd0, cases[k].exp_csum});
      chk("case_words", {16'd0, words_copied}, {16'd0, cases[k].len});
      chk("case_nwrites", nw - bw, {16'd0, cases[k].len});
      for (int i = 0; i < int'(cases[k].len); i++) begin
        ea = cases[k].src + 22'(i);
        ra = cases[k].dst + 18'(i);
        chk("case_flash_addr", {10'd0, flog[bf + i]}, {10'd0, ea});
        chk("case_ram_addr", {14'd0, rlog_addr[bw + i]}, {14'd0, ra});
        chk("case_ram_data", {16'd0, rlog_data[bw + i]}, {16'd0, fdata(ea)});
      end
      if (k == 0) begin
        chk("wrap_f0", {10'd0, flog[bf]},     32'h3FFFFE);
        chk("wrap_f1", {10'd0, flog[bf + 1]}, 32'h3FFFFF);
        chk("wrap_f2", {10'd0, flog[bf + 2]}, 32'h000000);
        chk("wrap_r0", {14'd0, rlog_addr[bw]},     32'h3FFFF);
        chk("wrap_r1", {14'd0, rlog_addr[bw + 1]}, 32'h00000);
        chk("wrap_r2", {14'd0, rlog_addr[bw + 2]}, 32'h00001);
      end
      if (k == 3) chk("len0_no_requests", nreq - br, 32'd0);
      tick();
    end

    // Flash never answers: error exactly 8 cycles after flash_req rises.
    hold_flash = 1'b1;
    do_start(22'h0, 18'h0, 16'd2);
    chk("tmo_req_rose", {31'd0, bus.flash_req}, 32'd1);
    repeat (7) tick();
    chk("tmo_not_yet", {31'd0, error}, 32'd0);
    tick();
    chk("tmo_error", {31'd0, error}, 32'd1);
    chk("tmo_flash_req", {31'd0, bus.flash_req}, 32'd0);
    chk("tmo_boot_done", {31'd0, boot_done}, 32'd0);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    hold_flash = 1'b0;
    tick();
    do_start(22'h0, 18'h0, 16'd4);
    chk("tmo_restart_clears", {31'd0, error}, 32'd0);
    wait_end("tmo_rerun_wait");
    chk("tmo_rerun_done", {31'd0, boot_done}, 32'd1);
    chk("tmo_rerun_csum", {16'd0, checksum}, 32'h0000AAAA);

    // Spurious ram_done in FLASH_RD and a second start mid-copy.
    tick();
    bf = nf; bw = nw;
    spur_done = 1'b0; st_done = 1'b0; got = 1'b0;
    do_start(22'h0, 18'h100, 16'd4);
    for (int c = 0; c < 300 && !got; c++) begin
      spur_ram = (nw - bw == 1) && bus.flash_req && !spur_done;
      if (spur_ram) spur_done = 1'b1;
      if ((nw - bw == 2) && bus.ram_req && !st_done) begin
        cfg_src = 22'h55; cfg_dst = 18'h7; cfg_len = 16'd1;
        start = 1'b1;
        st_done = 1'b1;
      end else start = 1'b0;
      tick();
      if (boot_done || error) got = 1'b1;
    end
    spur_ram = 1'b0; start = 1'b0;
    chk("dist_done", {31'd0, boot_done}, 32'd1);
    chk("dist_csum", {16'd0, checksum}, 32'h0000AAAA);
    chk("dist_words", {16'd0, words_copied}, 32'd4);
    chk("dist_nwrites", nw - bw, 32'd4);
    for (int i = 0; i < 4; i++)
      chk("dist_ram_addr", {14'd0, rlog_addr[bw + i]}, 32'h100 + i);

    // Reset asserted while a RAM write is pending.
    tick();
    do_start(22'h30, 18'h40, 16'd4);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (bus.ram_req) got = 1'b1;
      else tick();
    end
    chk("rstmid_in_ram_wr", {31'd0, bus.ram_req}, 32'd1);
    rst = 1'b0;
    tick();
    chk_zero_outputs("rstmid");
    bf = nf; bw = nw;
    rst = 1'b1;
    tick();
    wait_end("rstmid_wait");
    chk("rstmid_restart_src", {10'd0, flog[bf]}, 32'd0);
    chk("rstmid_csum", {16'd0, checksum}, 32'h0000AAAA);
    chk("rstmid_words", {16'd0, words_copied}, 32'd4);
    chk("rstmid_ram_addr0", {14'd0, rlog_addr[bw]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
